// File: rtl/fft_pkg.sv
// Shared types and helpers for the fft frame controller.
//   fft_ctrl_state_t : controller FSM states
//   bitrev()         : reverse the low m bits of an index
//   cabs1()          : L1 magnitude |re|+|im| of a complex value
package fft_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_M     = 9;
    localparam int unsigned N         = 1 << DEF_M;
    localparam int unsigned NBINS     = N / 2;

    // Widest index / component the helpers accept; callers size-cast in and out.
    localparam int unsigned MAX_M = 16;
    localparam int unsigned MAX_W = 32;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_COLLECT,
        ST_START,
        ST_WAIT,
        ST_ISSUE,
        ST_PRESENT
    } fft_ctrl_state_t;

    // Reverse all MAX_M bits, then shift the meaningful m bits back down.
    function automatic logic [MAX_M-1:0] bitrev(input logic [MAX_M-1:0] x, input int unsigned m);
        logic [MAX_M-1:0] r;
        r = {<<{x}};
        return r >> (MAX_M - m);
    endfunction

    // One extra bit of range so |most negative| needs no saturation.
    function automatic logic [MAX_W:0] cabs1(input logic signed [MAX_W-1:0] re,
                                             input logic signed [MAX_W-1:0] im);
        logic signed [MAX_W:0] re_x;
        logic signed [MAX_W:0] im_x;
        re_x = {re[MAX_W-1], re};
        im_x = {im[MAX_W-1], im};
        if (re_x[MAX_W]) re_x = -re_x;
        if (im_x[MAX_W]) im_x = -im_x;
        return $unsigned(re_x) + $unsigned(im_x);
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Bundles the sample stream, the fft core load/start/done interface and the
// result bin stream of fft_frame_ctrl.
//   master : controller side (drives smp_ready, fft_*, bin_*, frame_done)
//   slave  : environment side (sample source, fft core, bin sink)
interface fft_frame_ctrl_if #(
    parameter int unsigned width = 16,
    parameter int unsigned M     = 9
) ();

    logic                      smp_valid;
    logic                      smp_ready;
    logic signed [width-1:0]   smp;
    logic                      fft_rst;
    logic                      fft_load;
    logic [M-1:0]              fft_adr;
    logic [2*width-1:0]        fft_rd;
    logic                      fft_start;
    logic                      fft_done;
    logic [2*width-1:0]        fft_wd;
    logic                      bin_valid;
    logic                      bin_ready;
    logic [M-2:0]              bin_idx;
    logic signed [width-1:0]   bin_re;
    logic signed [width-1:0]   bin_im;
    logic [width:0]            bin_mag;
    logic                      frame_done;

    modport master (
        input  smp_valid, smp, fft_done, fft_wd, bin_ready,
        output smp_ready, fft_rst, fft_load, fft_adr, fft_rd, fft_start,
               bin_valid, bin_idx, bin_re, bin_im, bin_mag, frame_done
    );

    modport slave (
        output smp_valid, smp, fft_done, fft_wd, bin_ready,
        input  smp_ready, fft_rst, fft_load, fft_adr, fft_rd, fft_start,
               bin_valid, bin_idx, bin_re, bin_im, bin_mag, frame_done
    );

endinterface

// File: rtl/fft_bin_reg.sv
// Result bin capture/hold register: latches one core result word plus its
// L1 magnitude and holds it stable until the downstream handshake.
//   capture  : load wd/k into the output registers and raise valid
//   ready    : downstream accept; accept_c = valid & ready
//   valid/idx/re/im/mag : registered bin outputs
module fft_bin_reg #(
    parameter int unsigned width = 16,
    parameter int unsigned M     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    capture,
    input  logic [M-2:0]            k,
    input  logic [2*width-1:0]      wd,
    input  logic                    ready,
    output logic                    valid,
    output logic [M-2:0]            idx,
    output logic signed [width-1:0] re,
    output logic signed [width-1:0] im,
    output logic [width:0]          mag,
    output logic                    accept_c
);
    import fft_pkg::*;

    logic signed [width-1:0] wd_re;
    logic signed [width-1:0] wd_im;

    assign wd_re    = wd[2*width-1 -: width];
    assign wd_im    = wd[width-1:0];
    assign accept_c = valid & ready;

    // Data registers only change on capture; valid drops on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            idx   <= '0;
            re    <= '0;
            im    <= '0;
            mag   <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            idx   <= k;
            re    <= wd_re;
            im    <= wd_im;
            mag   <= (width+1)'(cabs1(MAX_W'(wd_re), MAX_W'(wd_im)));
        end else if (accept_c) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller around an fft core: collects N prescaled real samples,
// loads them, pulses start, waits for done, streams bins 0..N/2-1 out and
// resets the core before the next frame.
//   clk, reset : clock, async active-low reset
//   bus        : sample stream, fft core interface and bin stream (master)
module fft_frame_ctrl #(
    parameter int unsigned width  = 16,
    parameter int unsigned M      = 9,
    parameter bit          BITREV = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    fft_frame_ctrl_if.master bus
);
    import fft_pkg::*;

    localparam int unsigned FRAME_N    = 1 << M;
    localparam int unsigned FRAME_BINS = FRAME_N / 2;

    fft_ctrl_state_t state, state_d;
    logic [M-1:0]       cnt, cnt_d;
    logic [M-2:0]       k, k_d;
    logic               smp_ready_q, smp_ready_d;
    logic               fft_rst_q, fft_rst_d;
    logic               fft_load_q, fft_load_d;
    logic               fft_start_q, fft_start_d;
    logic               frame_done_q, frame_done_d;
    logic [M-1:0]       fft_adr_q, fft_adr_d;
    logic [2*width-1:0] fft_rd_q, fft_rd_d;

    logic                    sample_fire_c;
    logic                    capture_c;
    logic                    bin_accept_c;
    logic                    bin_valid;
    logic signed [width-1:0] smp_shifted;
    logic [M-2:0]            k_inc;

    assign sample_fire_c = bus.smp_valid & smp_ready_q;
    assign smp_shifted   = bus.smp >>> M;
    assign k_inc         = k + (M-1)'(1);
    assign capture_c     = (state == ST_PRESENT) && !bin_valid;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        k_d          = k;
        smp_ready_d  = 1'b0;
        fft_rst_d    = 1'b0;
        fft_load_d   = 1'b0;
        fft_start_d  = 1'b0;
        frame_done_d = 1'b0;
        fft_adr_d    = fft_adr_q;
        fft_rd_d     = fft_rd_q;
        unique case (state)
            ST_CLEAR: begin
                state_d     = ST_COLLECT;
                smp_ready_d = 1'b1;
                cnt_d       = '0;
            end
            ST_COLLECT: begin
                smp_ready_d = 1'b1;
                if (sample_fire_c) begin
                    fft_load_d = 1'b1;
                    fft_adr_d  = BITREV ? M'(bitrev(MAX_M'(cnt), M)) : cnt;
                    fft_rd_d   = {smp_shifted, width'(0)};
                    cnt_d      = cnt + M'(1);
                    if (cnt == M'(FRAME_N - 1)) begin
                        state_d     = ST_START;
                        smp_ready_d = 1'b0;
                    end
                end
            end
            ST_START: begin
                fft_start_d = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.fft_done) begin
                    k_d       = '0;
                    fft_adr_d = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bin_accept_c) begin
                    if (k == (M-1)'(FRAME_BINS - 1)) begin
                        frame_done_d = 1'b1;
                        fft_rst_d    = 1'b1;
                        state_d      = ST_CLEAR;
                    end else begin
                        k_d       = k_inc;
                        fft_adr_d = M'(k_inc);
                        state_d   = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                fft_rst_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset lands in CLEAR with the core held in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_CLEAR;
            cnt          <= '0;
            k            <= '0;
            smp_ready_q  <= 1'b0;
            fft_rst_q    <= 1'b1;
            fft_load_q   <= 1'b0;
            fft_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            fft_adr_q    <= '0;
            fft_rd_q     <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            k            <= k_d;
            smp_ready_q  <= smp_ready_d;
            fft_rst_q    <= fft_rst_d;
            fft_load_q   <= fft_load_d;
            fft_start_q  <= fft_start_d;
            frame_done_q <= frame_done_d;
            fft_adr_q    <= fft_adr_d;
            fft_rd_q     <= fft_rd_d;
        end
    end

    fft_bin_reg #(.width(width), .M(M)) u_bin_reg (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture_c),
        .k        (k),
        .wd       (bus.fft_wd),
        .ready    (bus.bin_ready),
        .valid    (bin_valid),
        .idx      (bus.bin_idx),
        .re       (bus.bin_re),
        .im       (bus.bin_im),
        .mag      (bus.bin_mag),
        .accept_c (bin_accept_c)
    );

    assign bus.bin_valid  = bin_valid;
    assign bus.smp_ready  = smp_ready_q;
    assign bus.fft_rst    = fft_rst_q;
    assign bus.fft_load   = fft_load_q;
    assign bus.fft_start  = fft_start_q;
    assign bus.frame_done = frame_done_q;
    assign bus.fft_adr    = fft_adr_q;
    assign bus.fft_rd     = fft_rd_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: two instances (BITREV=0 and BITREV=1,
// M=3) run in lockstep from shared stimulus; a small core model returns
// fft_wd one cycle after fft_adr.
module tb_fft_frame_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned MM = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        smp_valid;
    logic [15:0] smp;
    logic        fft_done;
    logic        bin_ready;
    bit          wd_mode;
    logic [31:0] wd0, wd1;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl_if #(.width(W), .M(MM)) b0 ();
    fft_frame_ctrl_if #(.width(W), .M(MM)) b1 ();

    fft_frame_ctrl #(.width(W), .M(MM), .BITREV(1'b0)) u0 (.clk(clk), .reset(rst_n), .bus(b0));
    fft_frame_ctrl #(.width(W), .M(MM), .BITREV(1'b1)) u1 (.clk(clk), .reset(rst_n), .bus(b1));

    assign b0.smp_valid = smp_valid;
    assign b1.smp_valid = smp_valid;
    assign b0.smp       = smp;
    assign b1.smp       = smp;
    assign b0.fft_done  = fft_done;
    assign b1.fft_done  = fft_done;
    assign b0.bin_ready = bin_ready;
    assign b1.bin_ready = bin_ready;
    assign b0.fft_wd    = wd0;
    assign b1.fft_wd    = wd1;

    // Core result model: mode 0 -> {adr+1, -(adr+1)}, mode 1 -> {0x8000, 0x8000}
    function automatic logic [31:0] wd_model(input logic [2:0] adr, input bit mode);
        logic [15:0] v;
        v = 16'(adr) + 16'd1;
        return mode ? 32'h8000_8000 : {v, 16'd0 - v};
    endfunction

    always @(posedge clk) begin
        wd0 <= wd_model(b0.fft_adr, wd_mode);
        wd1 <= wd_model(b1.fft_adr, wd_mode);
    end

    task automatic release_check();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({b0.fft_rst, b0.smp_ready, b1.fft_rst, b1.smp_ready} !== 4'b1010)
            $display("FAIL clear_cycle: got %b want 1010", {b0.fft_rst, b0.smp_ready, b1.fft_rst, b1.smp_ready});
        else passed++;
        @(negedge clk);
        total++;
        if ({b0.fft_rst, b0.smp_ready, b1.fft_rst, b1.smp_ready} !== 4'b0101)
            $display("FAIL collect_entry: got %b want 0101", {b0.fft_rst, b0.smp_ready, b1.fft_rst, b1.smp_ready});
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; smp_valid = 1'b0; smp = '0; fft_done = 1'b0; bin_ready = 1'b0; wd_mode = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({b0.fft_rst, b0.smp_ready, b0.fft_load, b0.fft_start, b0.bin_valid, b0.frame_done,
             b1.fft_rst, b1.smp_ready, b1.fft_load, b1.fft_start, b1.bin_valid, b1.frame_done} !== 12'b100000_100000)
            $display("FAIL reset_flags: got %b want 100000100000",
                     {b0.fft_rst, b0.smp_ready, b0.fft_load, b0.fft_start, b0.bin_valid, b0.frame_done,
                      b1.fft_rst, b1.smp_ready, b1.fft_load, b1.fft_start, b1.bin_valid, b1.frame_done});
        else passed++;
        total++;
        if ({b0.fft_adr, b0.fft_rd, b0.bin_idx, b0.bin_re, b0.bin_im, b0.bin_mag} !== 86'd0)
            $display("FAIL reset_data0: got %h want 0", {b0.fft_adr, b0.fft_rd, b0.bin_idx, b0.bin_re, b0.bin_im, b0.bin_mag});
        else passed++;
        total++;
        if ({b1.fft_adr, b1.fft_rd, b1.bin_idx, b1.bin_re, b1.bin_im, b1.bin_mag} !== 86'd0)
            $display("FAIL reset_data1: got %h want 0", {b1.fft_adr, b1.fft_rd, b1.bin_idx, b1.bin_re, b1.bin_im, b1.bin_mag});
        else passed++;
        release_check();
    endtask

    // Loads one frame of 8 samples; gap inserts one idle cycle before sample 4.
    task automatic test_load(input bit gap);
        logic [15:0] sv  [8] = '{16'h0800, 16'hF800, 16'h7FFF, 16'h8000, 16'd4, 16'd5, 16'd6, 16'd7};
        logic [31:0] rdx [8] = '{32'h0100_0000, 32'hFF00_0000, 32'h0FFF_0000, 32'hF000_0000, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [2:0]  rev [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        for (int i = 0; i < 8; i++) begin
            if (gap && i == 4) begin
                smp_valid = 1'b0;
                @(negedge clk);
                total++;
                if ({b0.fft_load, b1.fft_load, b0.smp_ready} !== 3'b001)
                    $display("FAIL load_gap: got %b want 001", {b0.fft_load, b1.fft_load, b0.smp_ready});
                else passed++;
            end
            smp_valid = 1'b1;
            smp       = sv[i];
            @(negedge clk);
            total++;
            if ({b0.fft_load, b0.fft_adr, b0.fft_rd} !== {1'b1, 3'(i), rdx[i]})
                $display("FAIL load0 #%0d: got %h want %h", i, {b0.fft_load, b0.fft_adr, b0.fft_rd}, {1'b1, 3'(i), rdx[i]});
            else passed++;
            total++;
            if ({b1.fft_load, b1.fft_adr, b1.fft_rd} !== {1'b1, rev[i], rdx[i]})
                $display("FAIL load1_bitrev #%0d: got %h want %h", i, {b1.fft_load, b1.fft_adr, b1.fft_rd}, {1'b1, rev[i], rdx[i]});
            else passed++;
        end
        total++;
        if ({b0.smp_ready, b1.smp_ready, b0.fft_start, b1.fft_start} !== 4'b0000)
            $display("FAIL ready_drop: got %b want 0000", {b0.smp_ready, b1.smp_ready, b0.fft_start, b1.fft_start});
        else passed++;
        smp = 16'h1234;
        @(negedge clk);
        total++;
        if ({b0.fft_load, b1.fft_load, b0.fft_start, b1.fft_start} !== 4'b0011)
            $display("FAIL start_pulse: got %b want 0011", {b0.fft_load, b1.fft_load, b0.fft_start, b1.fft_start});
        else passed++;
        @(negedge clk);
        total++;
        if ({b0.fft_load, b1.fft_load, b0.fft_start, b1.fft_start, b0.smp_ready, b1.smp_ready} !== 6'b000000)
            $display("FAIL start_end: got %b want 000000",
                     {b0.fft_load, b1.fft_load, b0.fft_start, b1.fft_start, b0.smp_ready, b1.smp_ready});
        else passed++;
        smp_valid = 1'b0;
    endtask

    // Waits out a slow core, then drains the 4 bins; stall_k holds bin_ready low on that bin.
    task automatic test_bins(input bit mode, input int stall_k);
        int quiet;
        logic [15:0] exp_re, exp_im;
        logic [16:0] exp_mag;
        quiet     = 0;
        wd_mode   = mode;
        fft_done  = 1'b0;
        bin_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (b0.bin_valid !== 1'b0 || b1.bin_valid !== 1'b0 || b0.smp_ready !== 1'b0) quiet++;
        end
        total++;
        if (quiet !== 0) $display("FAIL wait_quiet: got %0d active cycles want 0", quiet);
        else passed++;
        fft_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (b0.bin_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (b0.bin_valid !== 1'b1) begin
                $display("FAIL bin_timeout k=%0d: got bin_valid=%b want 1", k, b0.bin_valid);
                fft_done = 1'b0;
                return;
            end
            passed++;
            exp_re  = mode ? 16'h8000 : 16'(k + 1);
            exp_im  = mode ? 16'h8000 : 16'd0 - 16'(k + 1);
            exp_mag = mode ? 17'h10000 : 17'(2 * (k + 1));
            total++;
            if ({b0.bin_idx, b0.bin_re, b0.bin_im, b0.bin_mag, b0.fft_adr} !== {2'(k), exp_re, exp_im, exp_mag, 3'(k)})
                $display("FAIL bin0 k=%0d: got %h want %h", k, {b0.bin_idx, b0.bin_re, b0.bin_im, b0.bin_mag, b0.fft_adr},
                         {2'(k), exp_re, exp_im, exp_mag, 3'(k)});
            else passed++;
            total++;
            if ({b1.bin_valid, b1.bin_idx, b1.bin_re, b1.bin_im, b1.bin_mag} !== {1'b1, 2'(k), exp_re, exp_im, exp_mag})
                $display("FAIL bin1 k=%0d: got %h want %h", k, {b1.bin_valid, b1.bin_idx, b1.bin_re, b1.bin_im, b1.bin_mag},
                         {1'b1, 2'(k), exp_re, exp_im, exp_mag});
            else passed++;
            if (k == stall_k) begin
                int moved;
                moved     = 0;
                bin_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if ({b0.bin_valid, b0.bin_idx, b0.bin_re, b0.bin_im, b0.bin_mag, b0.fft_adr} !==
                        {1'b1, 2'(k), exp_re, exp_im, exp_mag, 3'(k)}) moved++;
                    if ({b1.bin_valid, b1.bin_idx, b1.bin_re, b1.bin_im, b1.bin_mag} !==
                        {1'b1, 2'(k), exp_re, exp_im, exp_mag}) moved++;
                end
                total++;
                if (moved !== 0) $display("FAIL stall_hold k=%0d: got %0d changes want 0", k, moved);
                else passed++;
                bin_ready = 1'b1;
            end
            @(negedge clk);
            if (k < 3) begin
                total++;
                if ({b0.bin_valid, b1.bin_valid, b0.frame_done, b0.fft_rst, b0.fft_adr} !== {4'b0000, 3'(k + 1)})
                    $display("FAIL issue k=%0d: got %b want %b", k, {b0.bin_valid, b1.bin_valid, b0.frame_done, b0.fft_rst, b0.fft_adr},
                             {4'b0000, 3'(k + 1)});
                else passed++;
            end else begin
                fft_done = 1'b0;
                total++;
                if ({b0.frame_done, b1.frame_done, b0.fft_rst, b1.fft_rst, b0.bin_valid} !== 5'b11110)
                    $display("FAIL frame_done: got %b want 11110", {b0.frame_done, b1.frame_done, b0.fft_rst, b1.fft_rst, b0.bin_valid});
                else passed++;
                @(negedge clk);
                total++;
                if ({b0.frame_done, b1.frame_done, b0.fft_rst, b1.fft_rst, b0.smp_ready, b1.smp_ready} !== 6'b000011)
                    $display("FAIL next_frame: got %b want 000011",
                             {b0.frame_done, b1.frame_done, b0.fft_rst, b1.fft_rst, b0.smp_ready, b1.smp_ready});
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        // Reset while waiting for done.
        test_load(1'b0);
        fft_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({b0.fft_rst, b0.smp_ready, b0.bin_valid, b0.fft_load, b0.fft_adr} !== 7'b1000000)
            $display("FAIL reset_in_wait: got %b want 1000000", {b0.fft_rst, b0.smp_ready, b0.bin_valid, b0.fft_load, b0.fft_adr});
        else passed++;
        release_check();
        test_load(1'b0);
        // Reset while a bin is being presented.
        fft_done  = 1'b1;
        bin_ready = 1'b0;
        n = 0;
        while (b0.bin_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (b0.bin_valid !== 1'b1) $display("FAIL present_reach: got bin_valid=%b want 1", b0.bin_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({b0.bin_valid, b1.bin_valid, b0.bin_mag, b0.fft_rst} !== {2'b00, 17'd0, 1'b1})
            $display("FAIL reset_in_present: got %h want %h", {b0.bin_valid, b1.bin_valid, b0.bin_mag, b0.fft_rst},
                     {2'b00, 17'd0, 1'b1});
        else passed++;
        fft_done = 1'b0;
        release_check();
        test_load(1'b1);
        test_bins(1'b0, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load(1'b1);
        test_bins(1'b0, -1);
        test_load(1'b0);
        test_bins(1'b1, 2);
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Front/back-end controller for the fft core: the producer and consumer on the far side of the core's load/start/done interface.
- Accepts a real sample stream, prescales it, and loads it into the core using load, rd_adr and rd.
- Pulses start, waits for done, then streams the lower N/2 result bins out with a valid/ready handshake.
- Clears the core through its active-high reset and repeats, one frame at a time.

Parameters:
- width, 16, bits per real/imag component (matches the fft core)
- M, 9, log2 of the FFT point count N = 2^M
- BITREV, 0, when 1 the load address is the bit-reversed sample index

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- smp_valid  in  1  input sample valid
- smp_ready  out  1  controller can accept a sample
- smp  in  width  signed real sample
- fft_rst  out  1  active-high reset to the fft core
- fft_load  out  1  load strobe to the core
- fft_adr  out  M  load/readout address to the core
- fft_rd  out  2*width  complex load data {re, im}
- fft_start  out  1  one-cycle start pulse
- fft_done  in  1  core done level
- fft_wd  in  2*width  core result data; valid one cycle after fft_adr is presented
- bin_valid  out  1  result bin valid
- bin_ready  in  1  downstream accepts bin
- bin_idx  out  M-1  bin index 0..N/2-1
- bin_re, bin_im  out  width  signed result components
- bin_mag  out  width+1  unsigned |re|+|im|
- frame_done  out  1  one-cycle pulse after the last bin is accepted

Behaviour:
- Reset values:
  - State is CLEAR.
  - fft_rst=1.
  - smp_ready, fft_load, fft_start, bin_valid and frame_done are 0.
  - fft_adr, fft_rd, bin_idx, bin_re, bin_im and bin_mag are 0.
  - The sample counter is 0.
- States are CLEAR, COLLECT, START, WAIT, ISSUE, PRESENT.
- CLEAR:
  - fft_rst=1 for exactly one cycle, then COLLECT.
  - Entered from reset and after each frame.
- COLLECT:
  - smp_ready=1.
  - On smp_valid&smp_ready, registered outputs next cycle: fft_load=1; fft_adr = cnt (or bitrev(cnt) if BITREV); fft_rd = {smp >>> M, width'(0)}.
  - The shift is an arithmetic shift right by M to leave headroom for bit growth. The real part is sign-extended; the imaginary part is 0.
  - cnt increments.
  - fft_load is 0 in any cycle without a handshake.
  - When sample N-1 is accepted, smp_ready drops the next cycle and the state goes to START.
- START:
  - fft_load=0 and fft_start=1 for exactly one cycle, in the cycle after the last load.
  - Then WAIT.
- WAIT:
  - Stays until fft_done=1, sampled.
  - Then bin counter k=0 and ISSUE.
  - No timeout.
- ISSUE:
  - fft_adr=k for one cycle, then PRESENT.
- PRESENT:
  - In the first cycle, fft_wd is captured into bin_re/bin_im; bin_mag = |re|+|im| computed at width+1 bits. The abs of the most negative value is 2^(width-1) with no saturation.
  - bin_idx=k and bin_valid=1.
  - The output registers hold until bin_valid&bin_ready.
  - On handshake with k<N/2-1: k++, bin_valid=0, go to ISSUE.
  - On handshake with k=N/2-1: frame_done=1 for one cycle, go to CLEAR.
  - fft_adr holds k throughout PRESENT.
  - Throughput is at most 1 bin per 2 cycles.
- Samples arriving outside COLLECT are not accepted (smp_ready=0). Upstream must hold them.
- smp_valid is ignored when smp_ready=0.
- bin_ready is ignored when bin_valid=0.
- Async reset mid-frame:
  - All state is discarded and the partial frame is lost.
  - The state restarts in CLEAR, so the core is reset before the next load.
- Once bin_valid is asserted, bin_valid, bin_re, bin_im, bin_mag and bin_idx are stable until handshake.

Decomposition:
- Package fft_pkg holds:
  - state enum fft_ctrl_state_t
  - localparam N = 1<<M and NBINS = N/2
  - function bitrev(M-bit)
  - function cabs1 (|re|+|im|)
- Sub-module: fft_bin_reg, the PRESENT-stage capture/hold register with magnitude computation and the valid/ready hold logic.

Test Plan:
- Reset held low for 3 cycles with M=3:
  - Required: all outputs at their reset values.
  - After release: fft_rst=1 for exactly one cycle, then smp_ready=1.
- Feed smp = 0x0800, 0xF800, 0x7FFF, 0x8000, 4, 5, 6, 7 (M=3, BITREV=0):
  - fft_load asserts 8 times with fft_adr 0..7.
  - fft_rd = {0x0100,0}, {0xFF00,0}, {0x0FFF,0}, {0xF000,0}, ...
  - fft_start pulses once, one cycle after the 8th load.
  - smp_ready=0 from then on.
- Same load sequence with BITREV=1:
  - fft_adr sequence is 0,4,2,6,1,5,3,7.
- Hold fft_done=0 for 20 cycles, then 1; model fft_wd = {adr+1, -(adr+1)} with a 1-cycle latency:
  - Bins k=0..3 emitted with bin_re = k+1, bin_im = -(k+1), bin_mag = 2(k+1).
  - frame_done pulses once, then fft_rst=1 for one cycle.
- Toggle bin_ready low for 5 cycles mid-bin:
  - bin_valid, data, bin_idx and fft_adr held constant.
  - No bin dropped or duplicated.
  - fft_wd = {0x8000, 0x8000} gives bin_mag = 0x10000.
- Deassert reset during WAIT and again during PRESENT:
  - Returns to CLEAR.
  - bin_valid=0 immediately.
  - The next frame loads from fft_adr 0.
